// File: rtl/inst_rom_loader_pkg.sv
// rtl/inst_rom_loader_pkg.sv - shared types and constants for the instruction ROM loader
// Contents: loader FSM state codes, the NOP returned for out-of-range fetches,
//   and a helper that drops one byte into a lane of a 32-bit word.
package inst_rom_loader_pkg;

   typedef enum logic [1:0] {
      ROM_ST_IDLE = 2'd0,
      ROM_ST_LOAD = 2'd1,
      ROM_ST_RUN  = 2'd2
   } rom_state_e;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   // Little-endian byte placement: lane 0 is bits [7:0].
   function automatic logic [31:0] put_lane(input logic [31:0] word,
                                            input logic [1:0]  lane,
                                            input logic [7:0]  data);
      logic [31:0] res;
      res = word;
      res[int'(lane) * 8 +: 8] = data;
      return res;
   endfunction

endpackage

// File: rtl/inst_rom_loader_if.sv
// rtl/inst_rom_loader_if.sv - fetch port and byte-load stream of the instruction ROM
// Signals: romen/instaddr -> inst (core fetch port);
//   ld_start/ld_valid/ld_data/ld_last -> ld_ready (program byte stream).
// Modports: master = core plus byte source, slave = instruction ROM.
interface inst_rom_loader_if;
   logic        romen;
   logic [31:0] instaddr;
   logic [31:0] inst;
   logic        ld_start;
   logic        ld_valid;
   logic [7:0]  ld_data;
   logic        ld_last;
   logic        ld_ready;

   modport master (
      output romen, instaddr, ld_start, ld_valid, ld_data, ld_last,
      input  inst, ld_ready
   );

   modport slave (
      input  romen, instaddr, ld_start, ld_valid, ld_data, ld_last,
      output inst, ld_ready
   );
endinterface

// File: rtl/inst_rom_loader_byte_loader.sv
// rtl/inst_rom_loader_byte_loader.sv - byte-serial loader FSM (module rom_byte_loader)
// Ports: clk, rst (async, active-high);
//   ld_start/ld_valid/ld_data/ld_last in, ld_ready out: program byte stream;
//   ld_done (high in RUN), ld_count (words written in current/last load);
//   we/waddr/wdata: word write port into the ROM array.
module rom_byte_loader
   import inst_rom_loader_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ld_start,
   input  logic                  ld_valid,
   input  logic [7:0]            ld_data,
   input  logic                  ld_last,
   output logic                  ld_ready,
   output logic                  ld_done,
   output logic [DEPTH_LOG2:0]   ld_count,
   output logic                  we,
   output logic [DEPTH_LOG2-1:0] waddr,
   output logic [31:0]           wdata
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

   rom_state_e            state_q, state_d;
   logic [1:0]            bcnt_q;
   logic [31:0]           asm_q;
   logic [DEPTH_LOG2-1:0] wptr_q;
   logic [DEPTH_LOG2:0]   count_q;
   logic                  xfer;
   logic                  word_done;
   logic                  final_word;

   // A restart in the same cycle as a byte wins; that byte is dropped.
   assign xfer       = ld_valid & ld_ready & ~ld_start;
   assign word_done  = xfer & (ld_last | (bcnt_q == 2'd3));
   assign final_word = word_done & (ld_last | (wptr_q == '1));

   // The word is written on the same edge that accepts its closing byte.
   // Upper lanes of a partial word are already zero because asm_q is
   // cleared after every word and on every start.
   assign wdata    = put_lane(asm_q, bcnt_q, ld_data);
   assign waddr    = wptr_q;
   assign we       = word_done;
   assign ld_count = count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ROM_ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ROM_ST_IDLE: if (ld_start) state_d = ROM_ST_LOAD;
         ROM_ST_LOAD: if (final_word) state_d = ROM_ST_RUN;
         ROM_ST_RUN:  if (ld_start) state_d = ROM_ST_LOAD;
         default:     state_d = ROM_ST_IDLE;
      endcase
   end

   always_comb begin
      ld_ready = 1'b0;
      ld_done  = 1'b0;
      case (state_q)
         ROM_ST_LOAD: ld_ready = (count_q != FULL_COUNT);
         ROM_ST_RUN:  ld_done  = 1'b1;
         default:     ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcnt_q  <= 2'd0;
         asm_q   <= 32'h0;
         wptr_q  <= '0;
         count_q <= '0;
      end else if (ld_start) begin
         bcnt_q  <= 2'd0;
         asm_q   <= 32'h0;
         wptr_q  <= '0;
         count_q <= '0;
      end else if (xfer) begin
         if (word_done) begin
            bcnt_q  <= 2'd0;
            asm_q   <= 32'h0;
            wptr_q  <= wptr_q + 1'b1;
            count_q <= count_q + 1'b1;
         end else begin
            bcnt_q <= bcnt_q + 2'd1;
            asm_q  <= wdata;
         end
      end
   end

endmodule

// File: rtl/inst_rom_loader.sv
// rtl/inst_rom_loader.sv - instruction ROM with byte-serial program loader and core reset hold
// Ports: clk, rst (async, active-high); bus (inst_rom_loader_if.slave: fetch port
//   romen/instaddr/inst and load stream ld_start/ld_valid/ld_data/ld_last/ld_ready);
//   cpu_rst (core reset, high while not RUN), ld_done, ld_count, addr_err.
// Build option: INST_ROM_ADDR_CHECK_EN - out-of-range fetches return NOP and set
//   sticky addr_err; without it the address wraps and addr_err is 0.
module inst_rom_loader
   import inst_rom_loader_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   inst_rom_loader_if.slave     bus,
   output logic                 cpu_rst,
   output logic                 ld_done,
   output logic [DEPTH_LOG2:0]  ld_count,
   output logic                 addr_err
);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic                  we;
   logic [DEPTH_LOG2-1:0] waddr;
   logic [31:0]           wdata;
   logic                  ld_ready_w;
   logic [31:0]           mem [DEPTH];
   logic [31:0]           rdata;
   logic                  fetch_en;
   logic                  oor;
   logic                  unused_addr_bits;

   rom_byte_loader #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_loader (
      .clk      (clk),
      .rst      (rst),
      .ld_start (bus.ld_start),
      .ld_valid (bus.ld_valid),
      .ld_data  (bus.ld_data),
      .ld_last  (bus.ld_last),
      .ld_ready (ld_ready_w),
      .ld_done  (ld_done),
      .ld_count (ld_count),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata)
   );

   assign bus.ld_ready = ld_ready_w;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Release lags RUN entry by one edge; a restart re-asserts it on the
   // same edge the loader leaves RUN, so the core never fetches mid-load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_rst <= 1'b1;
      end else begin
         cpu_rst <= ~ld_done | bus.ld_start;
      end
   end

   assign fetch_en = bus.romen & ~cpu_rst;
   assign rdata    = mem[bus.instaddr[DEPTH_LOG2+1:2]];
   assign unused_addr_bits = ^{bus.instaddr[31:DEPTH_LOG2+2], bus.instaddr[1:0]};

`ifdef INST_ROM_ADDR_CHECK_EN
   localparam logic [31:0] DEPTH_BYTES = 32'(DEPTH) << 2;

   logic [31:0] count_bytes;
   logic        addr_err_q;

   assign count_bytes = {{(29 - DEPTH_LOG2){1'b0}}, ld_count, 2'b00};
   assign oor         = (bus.instaddr >= DEPTH_BYTES) | (bus.instaddr >= count_bytes);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_err_q <= 1'b0;
      end else if (bus.ld_start) begin
         addr_err_q <= 1'b0;
      end else if (fetch_en & oor) begin
         addr_err_q <= 1'b1;
      end
   end

   assign addr_err = addr_err_q;
`else
   assign oor      = 1'b0;
   assign addr_err = 1'b0;
`endif

   assign bus.inst = !fetch_en ? 32'h0 : (oor ? NOP_INST : rdata);

endmodule
